power_gate_sequencer: RTL

POWER_GATE_SEQUENCER -- requirements
Module: power_gate_sequencer

---
 rtl/power_gate_sequencer.sv | 101 ++++++++++
 1 files changed

// File: rtl/power_gate_sequencer.sv
// Serializes power-gate enable changes across standard-cell banks, one bank per settle window.
// Optional macro POWER_GATE_SEQUENCER_THROTTLE_EN adds a throttle input that allows only turn-offs while high.
module power_gate_sequencer #(
  parameter int NUM_BANKS     = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int IDX_W         = 2
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef POWER_GATE_SEQUENCER_THROTTLE_EN
  input  logic                 throttle,
`endif
  input  logic [NUM_BANKS-1:0] req_on,
  output logic [NUM_BANKS-1:0] bank_en,
  output logic [NUM_BANKS-1:0] ack,
  output logic                 busy,
  output logic [IDX_W-1:0]     cur_bank
);

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_BANKS-1:0] bank_en_q, bank_en_d;
  logic [IDX_W-1:0]     cur_bank_q, cur_bank_d;
  logic [7:0]           cnt_q, cnt_d;

  logic [NUM_BANKS-1:0] eligible;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_vld;

`ifdef POWER_GATE_SEQUENCER_THROTTLE_EN
  always_comb eligible = (req_on ^ bank_en_q) & ~({NUM_BANKS{throttle}} & req_on);
`else
  always_comb eligible = req_on ^ bank_en_q;
`endif

  // Scan from the farthest offset down so the nearest bank after cur_bank wins.
  always_comb begin
    logic [IDX_W-1:0] cand_idx;
    sel_vld  = 1'b0;
    sel_idx  = cur_bank_q;
    cand_idx = '0;
    for (int off = NUM_BANKS; off >= 1; off--) begin
      cand_idx = IDX_W'((int'(cur_bank_q) + off) % NUM_BANKS);
      if (eligible[cand_idx]) begin
        sel_vld = 1'b1;
        sel_idx = cand_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bank_en_d  = bank_en_q;
    cur_bank_d = cur_bank_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          bank_en_d[sel_idx] = ~bank_en_q[sel_idx];
          cur_bank_d         = sel_idx;
          cnt_d              = 8'(SETTLE_CYCLES);
          state_d            = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bank_en_q  <= '0;
      cur_bank_q <= IDX_W'(NUM_BANKS - 1);
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      bank_en_q  <= bank_en_d;
      cur_bank_q <= cur_bank_d;
      cnt_q      <= cnt_d;
    end
  end

  // The last SETTLE cycle (counter at zero) carries the done pulse.
  always_comb begin
    ack = '0;
    if (state_q == SETTLE && cnt_q == 8'd0) ack[cur_bank_q] = 1'b1;
  end

  assign busy     = (state_q == SETTLE);
  assign bank_en  = bank_en_q;
  assign cur_bank = cur_bank_q;

endmodule
